// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path.
// Holds the FSM state encoding, PID values and PID class decode.
package usb_rx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SYNC_WAIT,
    SYNC_CHECK,
    PID_WAIT,
    PID_CHECK,
    DATA_WAIT,
    DATA_STORE,
    DONE,
    ERR_WAIT
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_TOKEN,
    CLS_DATA,
    CLS_HAND
  } pid_cls_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // Upper nibble must be the complement of the lower one.
  function automatic pid_cls_t pid_class(
    input logic [7:0] pid
  );
    logic     ok;
    logic     tok;
    logic     dat;
    logic     hnd;
    pid_cls_t c;
    ok  = (pid[3:0] == ~pid[7:4]);
    tok = ok && (pid[3:0] == PID_OUT ||
                 pid[3:0] == PID_IN ||
                 pid[3:0] == PID_SETUP);
    dat = ok && (pid[3:0] == PID_DATA0 ||
                 pid[3:0] == PID_DATA1);
    hnd = ok && (pid[3:0] == PID_ACK ||
                 pid[3:0] == PID_NAK ||
                 pid[3:0] == PID_STALL);
    c = CLS_NONE;
    unique case (1'b1)
      tok:     c = CLS_TOKEN;
      dat:     c = CLS_DATA;
      hnd:     c = CLS_HAND;
      default: c = CLS_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rx_byte_counter.sv
// Post-PID byte counter for the receive control unit.
// Saturates at MAX so it can never wrap.
module rx_byte_counter #(
  parameter int MAX = 66
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       count_enable,
  output logic [6:0] count
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= 7'd0;
    end else if (clear) begin
      count <= 7'd0;
    end else if (count_enable &&
                 count < 7'(MAX)) begin
      count <= count + 7'd1;
    end
  end

endmodule

// File: rtl/rx_control_unit.sv
// USB receive packet control FSM: sync/PID checks,
// byte budget per PID class and FIFO write strobes.
module rx_control_unit
  import usb_rx_pkg::*;
#(
  parameter int MAX_DATA_BYTES = 66
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       shift_enable,
  input  logic       eop,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic [3:0] rx_pid,
  output logic       pkt_done,
  output logic [6:0] byte_count
);

  state_t     state;
  pid_cls_t   cls_q;
  pid_cls_t   cls_in;
  logic [7:0] byte_q;
  logic       eop_ev;
  logic [6:0] cls_min;
  logic [6:0] cls_max;
  logic       cnt_clear;
  logic       cnt_en;

  assign eop_ev = eop & shift_enable;
  assign cls_in = pid_class(byte_q);

  always_comb begin
    cls_min = 7'd0;
    cls_max = 7'd0;
    unique case (cls_q)
      CLS_TOKEN: begin
        cls_min = 7'd2;
        cls_max = 7'd2;
      end
      CLS_DATA: begin
        cls_min = 7'd2;
        cls_max = 7'(MAX_DATA_BYTES);
      end
      default: begin
        cls_min = 7'd0;
        cls_max = 7'd0;
      end
    endcase
  end

  assign cnt_clear = (state == IDLE) & d_edge;
  assign cnt_en    = (state == DATA_STORE);

  rx_byte_counter #(
    .MAX(MAX_DATA_BYTES)
  ) u_cnt (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (cnt_clear),
    .count_enable(cnt_en),
    .count       (byte_count)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      r_error <= 1'b0;
      rx_pid  <= 4'h0;
      cls_q   <= CLS_NONE;
      byte_q  <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (d_edge) begin
            state   <= SYNC_WAIT;
            r_error <= 1'b0;
          end
        end
        SYNC_WAIT, PID_WAIT: begin
          if (eop_ev) begin
            state   <= IDLE;
            r_error <= 1'b1;
          end else if (byte_received) begin
            byte_q <= rcv_data;
            state  <= (state == SYNC_WAIT) ?
                      SYNC_CHECK : PID_CHECK;
          end
        end
        SYNC_CHECK: begin
          if (byte_q == SYNC_BYTE) begin
            state <= PID_WAIT;
          end else begin
            state   <= ERR_WAIT;
            r_error <= 1'b1;
          end
        end
        PID_CHECK: begin
          if (cls_in != CLS_NONE) begin
            rx_pid <= byte_q[3:0];
            cls_q  <= cls_in;
            state  <= DATA_WAIT;
          end else begin
            state   <= ERR_WAIT;
            r_error <= 1'b1;
          end
        end
        DATA_WAIT: begin
          // A byte landing with EOP is a truncated byte.
          if (eop_ev) begin
            if (!byte_received &&
                byte_count >= cls_min &&
                byte_count <= cls_max) begin
              state <= DONE;
            end else begin
              state   <= IDLE;
              r_error <= 1'b1;
            end
          end else if (byte_received) begin
            if (byte_count < cls_max) begin
              state <= DATA_STORE;
            end else begin
              state   <= ERR_WAIT;
              r_error <= 1'b1;
            end
          end
        end
        DATA_STORE: state <= DATA_WAIT;
        DONE:       state <= IDLE;
        ERR_WAIT: begin
          r_error <= 1'b1;
          if (eop_ev) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rcving   = (state != IDLE) && (state != DONE);
  assign w_enable = (state == DATA_STORE);
  assign pkt_done = (state == DONE);

endmodule
